// File: rtl/ddr_cmd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ddr_cmd_scheduler
// Purpose : Open-page DDR4 command scheduler (ACT/RD/WR/PRE/PREA/REF) with
//           per-bank open-row tracking and TRCD/TRP/TRFC spacing.
// Revision: 1.0 - initial release
// ============================================================================
module ddr_cmd_scheduler #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRCD      = 4,
    parameter int TRP       = 4,
    parameter int TRFC      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 done,
    input  logic                 ref_req,
    output logic                 ref_ack,
    output logic                 cs_n,
    output logic                 act_n,
    output logic                 cke,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba
);
    localparam int c_BKW   = BGWIDTH + BAWIDTH;
    localparam int c_NBANK = 1 << c_BKW;
    localparam int c_TMAX  = (TRFC > TRP) ? ((TRFC > TRCD) ? TRFC : TRCD)
                                          : ((TRP > TRCD) ? TRP : TRCD);
    localparam int c_CNTW  = (c_TMAX < 1) ? 1 : $clog2(c_TMAX + 1);
    // A wait state lasts T-1 cycles; the command state itself is the first one
    localparam logic [c_CNTW-1:0] c_RCD_LD = c_CNTW'((TRCD > 1) ? TRCD - 2 : 0);
    localparam logic [c_CNTW-1:0] c_RP_LD  = c_CNTW'((TRP  > 1) ? TRP  - 2 : 0);
    localparam logic [c_CNTW-1:0] c_RFC_LD = c_CNTW'((TRFC > 1) ? TRFC - 2 : 0);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_PRE = 4'd1, S_WAIT_RP = 4'd2, S_ACT = 4'd3, S_WAIT_RCD = 4'd4,
        S_RW = 4'd5, S_PREA = 4'd6, S_WAIT_RPA = 4'd7, S_REF = 4'd8, S_WAIT_RFC = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        C_DES = 3'd0, C_ACT = 3'd1, C_RW = 3'd2, C_PRE = 3'd3, C_PREA = 3'd4, C_REF = 3'd5
    } cmd_t;

    state_t               r_state, w_state_nxt;
    cmd_t                 w_cmd;
    logic [c_CNTW-1:0]    r_cnt, w_cnt_nxt;
    logic                 w_ack_nxt, w_accept, w_hit;
    logic [c_BKW-1:0]     r_bank, w_bank;
    logic [ADDRWIDTH-1:0] r_row, w_row;
    logic [COLWIDTH-1:0]  r_col, w_col;
    logic                 r_wr, w_wr;
    logic [c_NBANK-1:0]   r_open;
    logic [ADDRWIDTH-1:0] r_open_row [c_NBANK];
    logic                 r_done, r_ref_ack, r_cs_n, r_act_n, r_cke;
    logic [ADDRWIDTH-1:0] r_a;
    logic [BGWIDTH-1:0]   r_bg;
    logic [BAWIDTH-1:0]   r_ba;

    // In IDLE the live request is the target; afterwards the latched copy
    assign w_bank = (r_state == S_IDLE) ? {req_bg, req_ba} : r_bank;
    assign w_row  = (r_state == S_IDLE) ? req_row : r_row;
    assign w_col  = (r_state == S_IDLE) ? req_col : r_col;
    assign w_wr   = (r_state == S_IDLE) ? req_wr  : r_wr;
    assign w_hit  = r_open[w_bank] && (r_open_row[w_bank] == w_row);

    assign req_ready = (r_state == S_IDLE) && r_cke && !ref_req;

    function automatic logic [ADDRWIDTH-1:0] f_cmd_a(input logic ras, input logic cas,
                                                     input logic we, input logic a10,
                                                     input logic [COLWIDTH-1:0] col);
        logic [ADDRWIDTH-1:0] v;
        v                 = '0;
        v[COLWIDTH-1:0]   = col;
        v[10]             = a10;
        v[16]             = ras;
        v[15]             = cas;
        v[14]             = we;
        return v;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cmd       = C_DES;
        w_ack_nxt   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cke && ref_req) begin
                    w_state_nxt = S_PREA;
                    w_cmd       = C_PREA;
                end else if (req_valid && req_ready) begin
                    w_accept = 1'b1;
                    if (w_hit) begin
                        w_state_nxt = S_RW;
                        w_cmd       = C_RW;
                    end else if (r_open[w_bank]) begin
                        w_state_nxt = S_PRE;
                        w_cmd       = C_PRE;
                    end else begin
                        w_state_nxt = S_ACT;
                        w_cmd       = C_ACT;
                    end
                end
            end
            S_PRE, S_WAIT_RP: begin
                if ((r_state == S_PRE && TRP <= 1) || (r_state == S_WAIT_RP && r_cnt == '0)) begin
                    w_state_nxt = S_ACT;
                    w_cmd       = C_ACT;
                end else if (r_state == S_PRE) begin
                    w_state_nxt = S_WAIT_RP;
                    w_cnt_nxt   = c_RP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNTW'(1);
                end
            end
            S_ACT, S_WAIT_RCD: begin
                if ((r_state == S_ACT && TRCD <= 1) || (r_state == S_WAIT_RCD && r_cnt == '0)) begin
                    w_state_nxt = S_RW;
                    w_cmd       = C_RW;
                end else if (r_state == S_ACT) begin
                    w_state_nxt = S_WAIT_RCD;
                    w_cnt_nxt   = c_RCD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNTW'(1);
                end
            end
            S_RW: w_state_nxt = S_IDLE;
            S_PREA, S_WAIT_RPA: begin
                if ((r_state == S_PREA && TRP <= 1) || (r_state == S_WAIT_RPA && r_cnt == '0)) begin
                    w_state_nxt = S_REF;
                    w_cmd       = C_REF;
                end else if (r_state == S_PREA) begin
                    w_state_nxt = S_WAIT_RPA;
                    w_cnt_nxt   = c_RP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNTW'(1);
                end
            end
            S_REF: begin
                w_state_nxt = S_WAIT_RFC;
                if (TRFC <= 1) w_ack_nxt = 1'b1;
                else           w_cnt_nxt = c_RFC_LD;
            end
            S_WAIT_RFC: begin
                // ack is held for its cycle inside WAIT_RFC so IDLE never sees a stale ref_req
                if (r_ref_ack)           w_state_nxt = S_IDLE;
                else if (r_cnt == '0)    w_ack_nxt   = 1'b1;
                else                     w_cnt_nxt   = r_cnt - c_CNTW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_open    <= '0;
            for (int i = 0; i < c_NBANK; i++) r_open_row[i] <= '0;
            r_bank    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_wr      <= 1'b0;
            r_done    <= 1'b0;
            r_ref_ack <= 1'b0;
            r_cke     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_act_n   <= 1'b1;
            r_a       <= '0;
            r_bg      <= '0;
            r_ba      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cke     <= 1'b1;
            r_ref_ack <= w_ack_nxt;
            r_done    <= (w_cmd == C_RW);
            if (w_accept) begin
                r_bank <= w_bank;
                r_row  <= w_row;
                r_col  <= w_col;
                r_wr   <= w_wr;
            end
            r_cs_n  <= (w_cmd == C_DES);
            r_act_n <= (w_cmd != C_ACT);
            r_a     <= '0;
            r_bg    <= '0;
            r_ba    <= '0;
            case (w_cmd)
                C_ACT: begin
                    r_a                <= w_row;
                    {r_bg, r_ba}       <= w_bank;
                    r_open[w_bank]     <= 1'b1;
                    r_open_row[w_bank] <= w_row;
                end
                C_RW: begin
                    r_a          <= f_cmd_a(1'b1, 1'b0, !w_wr, 1'b0, w_col);
                    {r_bg, r_ba} <= w_bank;
                end
                C_PRE: begin
                    r_a            <= f_cmd_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
                    {r_bg, r_ba}   <= w_bank;
                    r_open[w_bank] <= 1'b0;
                end
                C_PREA: begin
                    r_a    <= f_cmd_a(1'b0, 1'b1, 1'b0, 1'b1, '0);
                    r_open <= '0;
                end
                C_REF:   r_a <= f_cmd_a(1'b0, 1'b0, 1'b1, 1'b0, '0);
                default: r_a <= '0;
            endcase
        end
    end

    assign done    = r_done;
    assign ref_ack = r_ref_ack;
    assign cs_n    = r_cs_n;
    assign act_n   = r_act_n;
    assign cke     = r_cke;
    assign A       = r_a;
    assign bg      = r_bg;
    assign ba      = r_ba;

endmodule
`default_nettype wire

// File: doc/ddr_cmd_scheduler.md
DDR_CMD_SCHEDULER -- requirements
Module: ddr_cmd_scheduler

Interface
REQ-001 Parameter BGWIDTH, default 2: bank-group address width.
REQ-002 Parameter BAWIDTH, default 2: bank address width.
REQ-003 Parameter ADDRWIDTH, default 17: row address / A-bus width.
REQ-004 Parameter COLWIDTH, default 10: column width, driven on A[COLWIDTH-1:0].
REQ-005 Parameters TRCD, TRP, TRFC, defaults 4, 4, 8: minimum cycles from ACT->RD/WR, PRE->ACT, and REF->next command.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-010 req_wr  input  1  1 = write, 0 = read.
REQ-011 req_bg / req_ba / req_row / req_col  input  BGWIDTH / BAWIDTH / ADDRWIDTH / COLWIDTH  target address.
REQ-012 done  output  1  one-cycle pulse in the cycle RD/WR is issued.
REQ-013 ref_req  input  1  refresh request, level, held until ref_ack.
REQ-014 ref_ack  output  1  one-cycle pulse when the refresh wait completes.
REQ-015 cs_n, act_n, cke  output  1 each  DDR4 command pins.
REQ-016 A  output  ADDRWIDTH  address/command bus (A16=ras_n, A15=cas_n, A14=we_n when act_n=1).
REQ-017 bg / ba  output  BGWIDTH / BAWIDTH  command bank target.

Function
REQ-018 Idle cycles SHALL drive DES: cs_n=1, act_n=1, A=0, bg=0, ba=0.
REQ-019 Encodings (cs_n=0): ACT act_n=0, A=row; RD act_n=1, ras/cas/we=1/0/1, A[10]=0, A[COLWIDTH-1:0]=col; WR =1/0/0; PRE =0/1/0, A[10]=0; PREA =0/1/0, A[10]=1; REF =0/0/1. Unused A bits SHALL be 0.
REQ-020 Per-bank table: open flag plus open row for each of 2^(BGWIDTH+BAWIDTH) banks; ACT sets it, PRE clears its bank, PREA clears all.
REQ-021 FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW, PREA, WAIT_RPA, REF, WAIT_RFC.
REQ-022 req_ready SHALL be 1 only in IDLE with ref_req=0; the request is latched on acceptance.
REQ-023 On acceptance (cycle 0): row hit -> RW; bank closed -> ACT; different row open -> PRE. Each state issues its command in cycle 1.
REQ-024 Each command state SHALL be held exactly one cycle; WAIT_RP/WAIT_RCD SHALL load a down-counter so the next command issues exactly TRP/TRCD cycles after the previous one.
REQ-025 Latency from acceptance to RD/WR issue: hit 1, closed 1+TRCD, miss 1+TRP+TRCD cycles; done pulses in that cycle; the FSM returns to IDLE the next cycle.
REQ-026 Open-page policy: RD/WR SHALL NOT auto-precharge; the row stays open.
REQ-027 In IDLE with ref_req=1: PREA at cycle 1 (even if all banks are closed); after TRP, REF; after TRFC, ref_ack pulses and the FSM returns to IDLE.
REQ-028 Simultaneous ref_req and req_valid in IDLE: refresh wins; the request is not accepted.
REQ-029 ref_req rising during a request: the request completes first, then refresh starts from IDLE.
REQ-030 Wait counters SHALL be wide enough for max(TRCD,TRP,TRFC); a value of 1 means the next command issues in the adjacent cycle.

Reset
REQ-031 reset_n=0 SHALL immediately force: IDLE; all banks closed; counters 0; DES outputs; req_ready=0, done=0, ref_ack=0, cke=0.
REQ-032 cke SHALL go to 1 on the first clk edge after reset release; req_ready may assert from that cycle onward.
REQ-033 Reset mid-operation SHALL abort the in-flight command with no done or ref_ack pulse.

Verification
REQ-034 Closed bank: RD bg=1 ba=2 row=0x155 col=0x3 accepted at t0 -> ACT A=0x155 at t1, RD A=0x3 at t5, done at t5.
REQ-035 Hit: then RD same bank row=0x155 col=0x8 accepted -> RD 1 cycle after acceptance, with no ACT or PRE.
REQ-036 Miss: WR same bank row=0x2AA -> PRE at t1, ACT A=0x2AA at t5, WR (A14=0) at t9.
REQ-037 Refresh with req_valid=1 in the same IDLE cycle: PREA (A10=1) at t1, REF at t5, ref_ack at t13, then the request is accepted.
REQ-038 reset_n low during WAIT_RCD -> DES outputs immediately, no done pulse; the next request to the same bank issues ACT.
REQ-039 Back-to-back requests with req_valid held high: req_ready=0 between acceptances; every RD/WR is preceded by valid spacing.
